// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Parses ASCII register commands arriving byte-by-byte from a UART receiver.
//     write : 'W' <reg digit 0..3> <DP_WIDTH/4 hex digits> CR
//     read  : 'R' <reg digit 0..3> CR
//   Command letters and hex digits are case-insensitive. LF is ignored,
//   except while a read is waiting for the transmitter, where every byte
//   is dropped and flagged.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   i_rx_data    received byte
//   i_rx_valid   one-cycle strobe qualifying i_rx_data
//   i_tx_busy    hex-print transmitter busy
//   i_reg_rdata  read data for o_reg_addr (combinational external mux)
//   o_reg_wr     one-cycle register write strobe
//   o_reg_addr   register index for writes and reads
//   o_reg_wdata  write data, held between writes
//   o_tx_stb     one-cycle print request
//   o_tx_reg     register index to print
//   o_tx_data    value to print
//   o_err        one-cycle strobe on a malformed command or dropped byte
module uart_cmd_parser #(
    parameter int DP_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_tx_busy,
    input  logic [DP_WIDTH-1:0] i_reg_rdata,
    output logic                o_reg_wr,
    output logic [1:0]          o_reg_addr,
    output logic [DP_WIDTH-1:0] o_reg_wdata,
    output logic                o_tx_stb,
    output logic [1:0]          o_tx_reg,
    output logic [DP_WIDTH-1:0] o_tx_data,
    output logic                o_err
);

    localparam int NIB   = DP_WIDTH / 4;
    localparam int CNT_W = $clog2(NIB + 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        REG,
        DATA,
        EOL,
        TXWAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               cmd_is_wr;
    logic [CNT_W-1:0]   nib_cnt;
    logic [DP_WIDTH-1:0] sr;

    // Decoded actions for the current cycle
    logic set_cmd;
    logic set_cmd_wr;
    logic addr_load;
    logic shift_en;
    logic cnt_clr;
    logic wr_go;
    logic tx_go;
    logic err_go;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        logic [7:0] t;
        if (b <= 8'h39)
            t = b - 8'h30;
        else if (b <= 8'h46)
            t = b - 8'h37;
        else
            t = b - 8'h57;
        return t[3:0];
    endfunction

    always_comb begin
        state_nxt  = state;
        set_cmd    = 1'b0;
        set_cmd_wr = 1'b0;
        addr_load  = 1'b0;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        wr_go      = 1'b0;
        tx_go      = 1'b0;
        err_go     = 1'b0;

        if (i_rx_valid) begin
            case (state)
                IDLE: begin
                    if (i_rx_data == 8'h57 || i_rx_data == 8'h77) begin
                        set_cmd    = 1'b1;
                        set_cmd_wr = 1'b1;
                        state_nxt  = REG;
                    end else if (i_rx_data == 8'h52 || i_rx_data == 8'h72) begin
                        set_cmd   = 1'b1;
                        state_nxt = REG;
                    end else if (i_rx_data != CH_CR && i_rx_data != CH_LF) begin
                        err_go = 1'b1;
                    end
                end
                REG: begin
                    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h33) begin
                        addr_load = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = cmd_is_wr ? DATA : EOL;
                    end else if (i_rx_data != CH_LF) begin
                        err_go    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    if (is_hex(i_rx_data)) begin
                        shift_en = 1'b1;
                        if (nib_cnt == CNT_W'(NIB - 1))
                            state_nxt = EOL;
                    end else if (i_rx_data != CH_LF) begin
                        err_go    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EOL: begin
                    if (i_rx_data == CH_CR) begin
                        if (cmd_is_wr) begin
                            wr_go     = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = TXWAIT;
                        end
                    end else if (i_rx_data != CH_LF) begin
                        err_go    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                TXWAIT: begin
                    // Nothing may be parsed while the read is pending.
                    err_go = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end

        // The pending read is issued regardless of any dropped byte.
        if (state == TXWAIT && !i_tx_busy) begin
            tx_go     = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_is_wr   <= 1'b0;
            nib_cnt     <= '0;
            sr          <= '0;
            o_reg_wr    <= 1'b0;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
            o_tx_stb    <= 1'b0;
            o_tx_reg    <= '0;
            o_tx_data   <= '0;
            o_err       <= 1'b0;
        end else begin
            o_reg_wr <= wr_go;
            o_tx_stb <= tx_go;
            o_err    <= err_go;
            if (set_cmd)
                cmd_is_wr <= set_cmd_wr;
            // ASCII '0'..'3' carry the index in their two low bits.
            if (addr_load)
                o_reg_addr <= i_rx_data[1:0];
            if (cnt_clr)
                nib_cnt <= '0;
            else if (shift_en)
                nib_cnt <= nib_cnt + CNT_W'(1);
            if (shift_en)
                sr <= {sr[DP_WIDTH-5:0], hex_val(i_rx_data)};
            if (wr_go)
                o_reg_wdata <= sr;
            if (tx_go) begin
                o_tx_data <= i_reg_rdata;
                o_tx_reg  <= o_reg_addr;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Scenario tasks drive byte streams into uart_cmd_parser and compare every
//   output each cycle with a reference model. The model tracks the text of
//   the partially received command and judges each byte against the command
//   grammar, rather than following a state machine.
module tb_uart_cmd_parser;

    localparam int DP_WIDTH = 16;
    localparam int NIB      = DP_WIDTH / 4;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          i_rx_data = 8'h00;
    logic                i_rx_valid = 1'b0;
    logic                i_tx_busy = 1'b0;
    logic [DP_WIDTH-1:0] i_reg_rdata;
    logic                o_reg_wr;
    logic [1:0]          o_reg_addr;
    logic [DP_WIDTH-1:0] o_reg_wdata;
    logic                o_tx_stb;
    logic [1:0]          o_tx_reg;
    logic [DP_WIDTH-1:0] o_tx_data;
    logic                o_err;

    always #5 clk = ~clk;

    uart_cmd_parser #(.DP_WIDTH(DP_WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .i_tx_busy   (i_tx_busy),
        .i_reg_rdata (i_reg_rdata),
        .o_reg_wr    (o_reg_wr),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .o_tx_stb    (o_tx_stb),
        .o_tx_reg    (o_tx_reg),
        .o_tx_data   (o_tx_data),
        .o_err       (o_err)
    );

    // External register file seen by the parser
    logic [DP_WIDTH-1:0] tb_regs [4] = '{16'h0F0F, 16'h1234, 16'h5A5A, 16'h3C3C};
    assign i_reg_rdata = tb_regs[o_reg_addr];
    always @(posedge clk) if (o_reg_wr) tb_regs[o_reg_addr] <= o_reg_wdata;

    // Reference model state
    logic [DP_WIDTH-1:0] mregs [4] = '{16'h0F0F, 16'h1234, 16'h5A5A, 16'h3C3C};
    logic [7:0]          mbuf [$];
    logic                pending = 1'b0;
    logic                e_wr = 1'b0, e_stb = 1'b0, e_err = 1'b0;
    logic [1:0]          m_addr = 2'd0, m_txreg = 2'd0;
    logic [DP_WIDTH-1:0] m_wdata = '0, m_txdata = '0;

    int total = 0;
    int bad   = 0;

    function automatic logic [38:0] obs();
        return {o_reg_wr, o_reg_addr, o_reg_wdata, o_tx_stb, o_tx_reg, o_tx_data, o_err};
    endfunction

    function automatic logic [38:0] mdl();
        return {e_wr, m_addr, m_wdata, e_stb, m_txreg, m_txdata, e_err};
    endfunction

    function automatic logic is_w(input logic [7:0] b);
        return b == 8'h57 || b == 8'h77;
    endfunction

    function automatic logic is_r(input logic [7:0] b);
        return b == 8'h52 || b == 8'h72;
    endfunction

    function automatic logic is_hexc(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic int hexval(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
        if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
        return int'(b) - 87;
    endfunction

    // One clock: drive inputs at the falling edge, advance the model to the
    // values the outputs must show after the next rising edge, then return
    // 1 time unit past that edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic b);
        int p;
        int val;
        logic ok;
        @(negedge clk);
        rst = r; i_rx_valid = v; i_rx_data = d; i_tx_busy = b;
        e_wr = 1'b0; e_stb = 1'b0; e_err = 1'b0;
        if (r) begin
            m_addr = '0; m_wdata = '0; m_txreg = '0; m_txdata = '0;
            mbuf.delete();
            pending = 1'b0;
        end else if (pending) begin
            if (v) e_err = 1'b1;
            if (!b) begin
                e_stb    = 1'b1;
                m_txreg  = m_addr;
                m_txdata = mregs[m_addr];
                pending  = 1'b0;
            end
        end else if (v && d != LF) begin
            p = mbuf.size();
            if (d == CR) begin
                if (p == 0) begin
                    // blank line
                end else if (is_w(mbuf[0]) && p == NIB + 2) begin
                    val = 0;
                    for (int i = 2; i < NIB + 2; i++) val = val * 16 + hexval(mbuf[i]);
                    e_wr    = 1'b1;
                    m_wdata = DP_WIDTH'(val);
                    mregs[m_addr] = DP_WIDTH'(val);
                    mbuf.delete();
                end else if (is_r(mbuf[0]) && p == 2) begin
                    pending = 1'b1;
                    mbuf.delete();
                end else begin
                    e_err = 1'b1;
                    mbuf.delete();
                end
            end else begin
                ok = (p == 0 && (is_w(d) || is_r(d))) ||
                     (p == 1 && d >= 8'h30 && d <= 8'h33) ||
                     (p >= 2 && p <= NIB + 1 && is_w(mbuf[0]) && is_hexc(d));
                if (!ok) begin
                    e_err = 1'b1;
                    mbuf.delete();
                end else begin
                    mbuf.push_back(d);
                    if (p == 1) m_addr = 2'(d - 8'h30);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, c == 1, 8'h57, 1'b0);
            total++;
            if (obs() !== 39'd0) begin
                bad++;
                $display("FAIL reset_outputs got=%h exp=0", obs());
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (obs() !== mdl()) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs(), mdl());
        end
    endtask

    task automatic test_read();
        string s = "r1\015";
        int stb_at = -1;
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, 1'b1, s[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL read_seq got=%h exp=%h", obs(), mdl());
            end
        end
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL read_idle got=%h exp=%h", obs(), mdl());
            end
            if (o_tx_stb && stb_at < 0) stb_at = c + 1;
        end
        total++;
        if (stb_at != 2 || o_tx_reg !== 2'd1 || o_tx_data !== 16'h1234) begin
            bad++;
            $display("FAIL read_r1 stb_cycle=%0d reg=%0d data=%h exp 2/1/1234", stb_at, o_tx_reg, o_tx_data);
        end
    endtask

    task automatic test_busy_wait();
        string s = "R3\015";
        int errs = 0;
        int stbs = 0;
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, 1'b1, s[i], 1'b1);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL busy_cmd got=%h exp=%h", obs(), mdl());
            end
        end
        for (int c = 0; c < 40; c++) begin
            step(1'b0, c == 10, (c == 10) ? 8'h58 : 8'h00, 1'b1);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL busy_wait got=%h exp=%h", obs(), mdl());
            end
            if (o_err) errs++;
            if (o_tx_stb) stbs++;
        end
        total++;
        if (errs != 1 || stbs != 0) begin
            bad++;
            $display("FAIL busy_hold errs=%0d stbs=%0d exp 1/0", errs, stbs);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (o_tx_stb !== 1'b1 || o_tx_reg !== 2'd3 || o_tx_data !== 16'h3C3C) begin
            bad++;
            $display("FAIL busy_release stb=%b reg=%0d data=%h exp 1/3/3c3c", o_tx_stb, o_tx_reg, o_tx_data);
        end
        stbs = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            if (o_tx_stb) stbs++;
        end
        total++;
        if (stbs != 0) begin
            bad++;
            $display("FAIL busy_second_stb count=%0d exp 0", stbs);
        end
    endtask

    task automatic test_write();
        string s = "W2BEEF\015";
        int errs = 0;
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, 1'b1, s[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL write_seq got=%h exp=%h", obs(), mdl());
            end
            if (o_err) errs++;
            if (i < s.len() - 1 && o_reg_wr) begin
                total++; bad++;
                $display("FAIL write_early wr=1 at byte %0d exp 0", i);
            end
        end
        total++;
        if (o_reg_wr !== 1'b1 || o_reg_addr !== 2'd2 || o_reg_wdata !== 16'hBEEF || errs != 0) begin
            bad++;
            $display("FAIL write_beef wr=%b addr=%0d data=%h errs=%0d exp 1/2/beef/0", o_reg_wr, o_reg_addr, o_reg_wdata, errs);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (o_reg_wr !== 1'b0 || o_reg_wdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_width wr=%b data=%h exp 0/beef", o_reg_wr, o_reg_wdata);
        end
    endtask

    task automatic test_bad_hex();
        string s = "W1AB\015w1abcd\n\015";
        int wrs = 0;
        int err_at_cr = 0;
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, 1'b1, s[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL badhex_seq got=%h exp=%h", obs(), mdl());
            end
            if (i == 4 && o_err) err_at_cr = 1;
            if (i <= 4 && o_reg_wr) wrs++;
        end
        total++;
        if (err_at_cr != 1 || wrs != 0 || o_reg_wr !== 1'b1 || o_reg_addr !== 2'd1 || o_reg_wdata !== 16'hABCD) begin
            bad++;
            $display("FAIL badhex_then_write errcr=%0d early_wr=%0d wr=%b addr=%0d data=%h exp 1/0/1/1/abcd",
                     err_at_cr, wrs, o_reg_wr, o_reg_addr, o_reg_wdata);
        end
    endtask

    task automatic test_bad_reg();
        string s = "W5R0\015";
        int stbs = 0;
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, 1'b1, s[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL badreg_seq got=%h exp=%h", obs(), mdl());
            end
            if (i == 1 && o_err !== 1'b1) begin
                total++; bad++;
                $display("FAIL badreg_err err=%b exp 1", o_err);
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL badreg_idle got=%h exp=%h", obs(), mdl());
            end
            if (o_tx_stb) stbs++;
        end
        total++;
        if (stbs != 1 || o_tx_reg !== 2'd0 || o_tx_data !== mregs[0]) begin
            bad++;
            $display("FAIL badreg_read0 stbs=%0d reg=%0d data=%h exp 1/0/%h", stbs, o_tx_reg, o_tx_data, mregs[0]);
        end
    endtask

    task automatic test_reset_mid();
        string s1 = "W3DE";
        string s2 = "AD\015";
        int errs = 0;
        int wrs = 0;
        for (int i = 0; i < s1.len(); i++) begin
            step(1'b0, 1'b1, s1[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL rstmid_pre got=%h exp=%h", obs(), mdl());
            end
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b1, c == 0, 8'h41, 1'b0);
            total++;
            if (obs() !== 39'd0) begin
                bad++;
                $display("FAIL rstmid_zero got=%h exp=0", obs());
            end
        end
        for (int i = 0; i < s2.len(); i++) begin
            step(1'b0, 1'b1, s2[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL rstmid_post got=%h exp=%h", obs(), mdl());
            end
            if (o_err) errs++;
            if (o_reg_wr) wrs++;
        end
        total++;
        if (errs != 2 || wrs != 0) begin
            bad++;
            $display("FAIL rstmid_result errs=%0d wrs=%0d exp 2/0", errs, wrs);
        end
    endtask

    task automatic test_back_to_back();
        string s = "W0CAFE\015R0\015X";
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, 1'b1, s[i], 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL b2b_seq got=%h exp=%h", obs(), mdl());
            end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        total++;
        if (o_tx_data !== 16'hCAFE || o_tx_reg !== 2'd0) begin
            bad++;
            $display("FAIL b2b_readback data=%h reg=%0d exp cafe/0", o_tx_data, o_tx_reg);
        end
    endtask

    task automatic test_random();
        string hx = "0123456789ABCDEFabcdef";
        logic [7:0] q [$];
        logic [7:0] b;
        int kind;
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3 || kind == 8) begin
                q.push_back(($urandom_range(0, 1) != 0) ? 8'h57 : 8'h77);
                q.push_back(8'h30 + 8'($urandom_range(0, 3)));
                for (int k = 0; k < ((kind == 8) ? 2 : NIB); k++) begin
                    q.push_back(hx[$urandom_range(0, 21)]);
                    if ($urandom_range(0, 15) == 0) q.push_back(LF);
                end
                q.push_back(CR);
            end else if (kind <= 6) begin
                q.push_back(($urandom_range(0, 1) != 0) ? 8'h52 : 8'h72);
                q.push_back(8'h30 + 8'($urandom_range(0, (kind == 6) ? 9 : 3)));
                q.push_back(CR);
            end else if (kind == 7) begin
                q.push_back(8'($urandom_range(0, 255)));
            end else begin
                q.push_back(($urandom_range(0, 1) != 0) ? LF : CR);
            end
        end
        foreach (q[i]) begin
            while ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'b0, 8'h00, $urandom_range(0, 2) == 0);
                total++;
                if (obs() !== mdl() || (o_reg_wr && o_tx_stb)) begin
                    bad++;
                    $display("FAIL rand_gap got=%h exp=%h", obs(), mdl());
                end
            end
            b = q[i];
            step($urandom_range(0, 199) == 0, 1'b1, b, $urandom_range(0, 2) == 0);
            total++;
            if (obs() !== mdl() || (o_reg_wr && o_tx_stb)) begin
                bad++;
                $display("FAIL rand_byte byte=%h got=%h exp=%h", b, obs(), mdl());
            end
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b0, 8'h00, 1'b0);
            total++;
            if (obs() !== mdl()) begin
                bad++;
                $display("FAIL rand_drain got=%h exp=%h", obs(), mdl());
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_busy_wait();
        test_write();
        test_bad_hex();
        test_bad_reg();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter: DP_WIDTH, default 16, register data width in bits; SHALL be a multiple of 4; NIB = DP_WIDTH/4 hex digits per value.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_rx_data  input  8  received byte from the UART receiver.
REQ-005 i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-006 i_tx_busy  input  1  high while the hex-print transmitter is printing.
REQ-007 i_reg_rdata  input  DP_WIDTH  read data for register o_reg_addr, combinational from an external mux.
REQ-008 o_reg_wr  output  1  one-cycle register write strobe.
REQ-009 o_reg_addr  output  2  register index for writes and reads.
REQ-010 o_reg_wdata  output  DP_WIDTH  write data; held stable between writes.
REQ-011 o_tx_stb  output  1  one-cycle print request to the transmitter.
REQ-012 o_tx_reg  output  2  register index to print.
REQ-013 o_tx_data  output  DP_WIDTH  value to print.
REQ-014 o_err  output  1  one-cycle strobe on a malformed command or a dropped byte.

Function
REQ-015 Accepted grammar: write "W" d h(NIB) CR; read "R" d CR.
- W/R are case-insensitive.
- d is "0".."3".
- h is 0-9, A-F or a-f.
- CR is 0x0D.
REQ-016 LF (0x0A) SHALL be ignored in every state except TXWAIT.
REQ-017 Bytes are consumed only in cycles with i_rx_valid high; all outputs are registered.
REQ-018 FSM states are IDLE, REG, DATA, EOL and TXWAIT.
REQ-019 IDLE transitions:
- W/R: record the command type, go to REG.
- CR: stay in IDLE, no error.
- Any other byte: pulse o_err, stay in IDLE.
REQ-020 REG transitions:
- Digit "0".."3": load o_reg_addr.
- Then go to DATA for a write, or EOL for a read.
- Any other byte: pulse o_err, go to IDLE.
REQ-021 DATA:
- Each hex digit shifts into an internal shift register MSB-first: sr <= {sr[DP_WIDTH-5:0], nib}.
- A nibble counter counts 0..NIB.
- After the NIB-th digit, go to EOL.
- A non-hex byte, including an early CR, pulses o_err and goes to IDLE with no write.
REQ-022 EOL, write command: CR pulses o_reg_wr and loads o_reg_wdata <= sr in the cycle after the CR strobe, then goes to IDLE.
REQ-023 EOL, read command: CR goes to TXWAIT.
REQ-024 EOL, any other byte: pulse o_err, go to IDLE.
REQ-025 TXWAIT, in any cycle with i_tx_busy low:
- Capture o_tx_data <= i_reg_rdata and o_tx_reg <= o_reg_addr.
- Drive o_tx_stb high in the next cycle for exactly one cycle.
- Go to IDLE.
- Earliest o_tx_stb is 2 cycles after the CR strobe.
REQ-026 TXWAIT with i_tx_busy high: wait indefinitely and issue no stb.
REQ-027 Any byte, including LF, received in TXWAIT SHALL be dropped with an o_err pulse; the pending read is still issued exactly once.
REQ-028 o_reg_wr and o_tx_stb SHALL never be asserted in the same cycle, and each SHALL be at most one cycle wide.
REQ-029 o_reg_addr SHALL change only on a valid register digit.
REQ-030 o_tx_reg and o_tx_data SHALL change only at stb capture and SHALL hold afterwards.
REQ-031 A byte error in any state SHALL discard the partial command; the next byte is parsed from IDLE.

Reset
REQ-032 While rst is high:
- State goes to IDLE; the nibble counter and shift register clear.
- All outputs are 0: o_reg_wr, o_reg_addr, o_reg_wdata, o_tx_stb, o_tx_reg, o_tx_data, o_err.
REQ-033 Reset mid-command or in TXWAIT SHALL abort it with no o_reg_wr, o_tx_stb or o_err.
REQ-034 i_rx_valid SHALL be ignored while rst is high.

Verification (DP_WIDTH=16)
REQ-035 "W2BEEF\r" -> o_reg_wr high for 1 cycle, the cycle after the CR strobe; o_reg_addr=2; o_reg_wdata=0xBEEF; o_err never high.
REQ-036 "r1\r", i_tx_busy=0, i_reg_rdata=0x1234 -> o_tx_stb for 1 cycle, 2 cycles after CR; o_tx_reg=1; o_tx_data=0x1234.
REQ-037 "R3\r" with i_tx_busy held high 40 cycles; byte "X" sent during the wait -> one o_err pulse; single o_tx_stb the cycle after busy falls +1; no second stb.
REQ-038 "W1AB\r" -> o_err at CR, no write; then "w1abcd\n\r" -> write with addr 1, data 0xABCD.
REQ-039 "W5" -> o_err at "5", back to IDLE; then "R0\r" -> normal read of register 0.
REQ-040 rst pulse after "W3DE", then "AD\r" -> no o_reg_wr; o_err on "A" and on "D"; all outputs 0 during reset.
